// File: rtl/fmdll_pkg.sv
// Purpose: shared types and constants for the FMDLL cycle counter and mux-select logic.
// Latency: none (declarations only).
// Backpressure: none.
package fmdll_pkg;

  // Frame tracker state: waiting for a reference edge, or counting a frame.
  typedef enum logic {
    ACQ = 1'b0,
    RUN = 1'b1
  } state_e;

  // Default counter widths.
  localparam int N_W_DEF = 4;
  localparam int M_W_DEF = 2;

  // Width of the good-frame counter; wide enough for LOCK_CNT up to 15.
  localparam int GOOD_W = 4;

  // Mux-select encodings consumed by the downstream select logic.
  typedef logic [1:0] sel_t;
  localparam sel_t SEL_EXT  = 2'b00;
  localparam sel_t SEL_OUT  = 2'b01;
  localparam sel_t SEL_HOLD = 2'b10;

endpackage

// File: rtl/fmdll_edge_sync.sv
// Purpose: samples the reference clock as data and flags its rising edges.
// Latency: 1 cycle to ext_rise; 3 cycles when SYNC_EXT_EN adds the 2-flop synchronizer.
// Backpressure: none; ext_rise is a free-running one-cycle flag.
module fmdll_edge_sync
  import fmdll_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ext_in,
  output logic ext_rise
);

  logic samp_q, samp_d;
  logic prev_q, prev_d;

`ifdef SYNC_EXT_EN
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state for the synchronizer chain, sample flop and previous-sample flop.
  always_comb begin
    meta_d = ext_in;
    sync_d = meta_q;
    samp_d = sync_q;
    prev_d = samp_q;
  end

  // Synchronizer, sample and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      samp_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      samp_q <= samp_d;
      prev_q <= prev_d;
    end
  end
`else
  // Next-state for the single sample flop and previous-sample flop.
  always_comb begin
    samp_d = ext_in;
    prev_d = samp_q;
  end

  // Sample and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      prev_q <= prev_d;
    end
  end
`endif

  // Rise: current sample high, previous sample low.
  assign ext_rise = samp_q & ~prev_q;

endmodule

// File: rtl/fmdll_cycle_counter.sv
// Purpose: N/M cycle indices, DIV_N/DIV_M pulses and reference-alignment lock/error status.
// Latency: ext edge to counters 1/1 is one cycle after detect; DIV_* combinational from counters; SYNC_EXT_EN adds reference synchronizer.
// Backpressure: none; all outputs are free-running status.
module fmdll_cycle_counter
  import fmdll_pkg::*;
#(
  parameter int N_W      = N_W_DEF,
  parameter int M_W      = M_W_DEF,
  parameter int LOCK_CNT = 4
) (
  input  logic           clk_out,
  input  logic           rst_n,
  input  logic           clk_ext,
  input  logic [N_W-1:0] N,
  input  logic [M_W-1:0] M,
  output logic [N_W-1:0] N_counter,
  output logic [M_W-1:0] M_counter,
  output logic           DIV_N,
  output logic           DIV_M,
  output logic           lock,
  output logic           err_early,
  output logic           err_late
);

  localparam logic [N_W-1:0]    N_ONE    = N_W'(1);
  localparam logic [M_W-1:0]    M_ONE    = M_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [N_W-1:0]    n_cnt_q, n_cnt_d;
  logic [M_W-1:0]    m_cnt_q, m_cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              lock_q, lock_d;
  logic              early_q, early_d;
  logic              late_q, late_d;

  logic              ext_rise;
  logic [N_W-1:0]    n_eff;
  logic [M_W-1:0]    m_eff;
  logic              sub_end;
  logic              frame_end;

  fmdll_edge_sync u_edge_sync (
    .clk      (clk_out),
    .rst_n    (rst_n),
    .ext_in   (clk_ext),
    .ext_rise (ext_rise)
  );

  // A zero limit behaves as one; >= compares let a lowered limit wrap immediately.
  always_comb begin
    n_eff     = (N == '0) ? N_ONE : N;
    m_eff     = (M == '0) ? M_ONE : M;
    sub_end   = (state_q == RUN) && (n_cnt_q >= n_eff);
    frame_end = sub_end && (m_cnt_q >= m_eff);
  end

  // Frame tracking, alignment check and lock qualification.
  always_comb begin
    state_d = state_q;
    n_cnt_d = n_cnt_q;
    m_cnt_d = m_cnt_q;
    good_d  = good_q;
    lock_d  = lock_q | (good_q == GOOD_MAX);
    early_d = 1'b0;
    late_d  = 1'b0;

    case (state_q)
      ACQ: begin
        n_cnt_d = '0;
        m_cnt_d = '0;
        if (ext_rise) begin
          n_cnt_d = N_ONE;
          m_cnt_d = M_ONE;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sub_end) begin
          n_cnt_d = N_ONE;
          m_cnt_d = (m_cnt_q >= m_eff) ? M_ONE : m_cnt_q + M_ONE;
        end else begin
          n_cnt_d = n_cnt_q + N_ONE;
        end

        if (ext_rise && frame_end) begin
          // Edge on the frame boundary: a good frame (wins over any error).
          good_d = (good_q >= GOOD_MAX) ? GOOD_MAX : good_q + GOOD_W'(1);
        end else if (ext_rise) begin
          // Edge inside the frame: re-phase on it and restart qualification.
          early_d = 1'b1;
          good_d  = '0;
          lock_d  = 1'b0;
          n_cnt_d = N_ONE;
          m_cnt_d = M_ONE;
        end else if (frame_end) begin
          // Frame closed with no edge: drop back and reacquire.
          late_d  = 1'b1;
          good_d  = '0;
          lock_d  = 1'b0;
          n_cnt_d = '0;
          m_cnt_d = '0;
          state_d = ACQ;
        end
      end
      default: begin
        state_d = ACQ;
        n_cnt_d = '0;
        m_cnt_d = '0;
        good_d  = '0;
        lock_d  = 1'b0;
      end
    endcase
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state_q <= ACQ;
      n_cnt_q <= '0;
      m_cnt_q <= '0;
      good_q  <= '0;
      lock_q  <= 1'b0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_cnt_q <= n_cnt_d;
      m_cnt_q <= m_cnt_d;
      good_q  <= good_d;
      lock_q  <= lock_d;
      early_q <= early_d;
      late_q  <= late_d;
    end
  end

  assign N_counter = n_cnt_q;
  assign M_counter = m_cnt_q;
  assign DIV_N     = sub_end;
  assign DIV_M     = frame_end;
  assign lock      = lock_q;
  assign err_early = early_q;
  assign err_late  = late_q;

endmodule

// File: tb/tb_fmdll_cycle_counter.sv
// Purpose: directed self-checking bench for fmdll_cycle_counter (default build, no reference synchronizer).
// Latency: outputs checked 1 time unit after each rising clk_out edge.
// Backpressure: none.
module tb_fmdll_cycle_counter;

  logic       clk_out = 1'b0;
  logic       rst_n;
  logic       clk_ext;
  logic [3:0] N;
  logic [1:0] M;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N;
  logic       DIV_M;
  logic       lock;
  logic       err_early;
  logic       err_late;

  int n_cmp = 0;
  int n_bad = 0;

  fmdll_cycle_counter #(
    .N_W      (4),
    .M_W      (2),
    .LOCK_CNT (4)
  ) dut (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .clk_ext   (clk_ext),
    .N         (N),
    .M         (M),
    .N_counter (N_counter),
    .M_counter (M_counter),
    .DIV_N     (DIV_N),
    .DIV_M     (DIV_M),
    .lock      (lock),
    .err_early (err_early),
    .err_late  (err_late)
  );

  always #5 clk_out = ~clk_out;

  // One comparison: counted, and reported on mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the reference level for one cycle and step past the next rising edge.
  task automatic cyc(input logic e);
    clk_ext = e;
    @(posedge clk_out);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".n"},     32'(N_counter), 0);
    chk({tag, ".m"},     32'(M_counter), 0);
    chk({tag, ".divn"},  32'(DIV_N),     0);
    chk({tag, ".divm"},  32'(DIV_M),     0);
    chk({tag, ".lock"},  32'(lock),      0);
    chk({tag, ".early"}, 32'(err_early), 0);
    chk({tag, ".late"},  32'(err_late),  0);
  endtask

  // N=4, M=2 with an 8-cycle reference (high 4, low 4). c counts cycles from the
  // reference-rise cycle; ext is forced low for c in [d0,d1]. Expected values after
  // call c>=1: N=(c-1)%4+1, M=((c-1)/4)%2+1, DIV_N every 4th, DIV_M every 8th.
  task automatic run(input string tag, input int c0, input int c1, input int lockc,
                     input int d0, input int d1);
    for (int c = c0; c <= c1; c++) begin
      cyc(((c % 8) < 4) && !(c >= d0 && c <= d1));
      if (c == 0) begin
        chk({tag, ".acq_n"}, 32'(N_counter), 0);
      end else begin
        chk({tag, ".n"},     32'(N_counter), 32'(((c - 1) % 4) + 1));
        chk({tag, ".m"},     32'(M_counter), 32'((((c - 1) / 4) % 2) + 1));
        chk({tag, ".divn"},  32'(DIV_N),     32'((c % 4) == 0));
        chk({tag, ".divm"},  32'(DIV_M),     32'((c % 8) == 0));
        chk({tag, ".lock"},  32'(lock),      32'(c >= lockc));
        chk({tag, ".early"}, 32'(err_early), 0);
        chk({tag, ".late"},  32'(err_late),  0);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    clk_ext = 1'b0;
    N       = 4'd4;
    M       = 2'd2;

    // Reset state.
    cyc(1'b0);
    cyc(1'b0);
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc(1'b0);
    chk("acq_idle.n", 32'(N_counter), 0);

    // Aligned reference: first rise acquires, 4 good frames then lock.
    run("lock1", 0, 40, 34, -1, -1);

    // Reference edge 2 cycles early.
    run("pre_early", 41, 45, 34, 44, 45);
    cyc(1'b1);
    chk("early_at.n",     32'(N_counter), 2);
    chk("early_at.m",     32'(M_counter), 2);
    chk("early_at.early", 32'(err_early), 0);
    chk("early_at.lock",  32'(lock),      1);
    cyc(1'b1);
    chk("early_p.early",  32'(err_early), 1);
    chk("early_p.n",      32'(N_counter), 1);
    chk("early_p.m",      32'(M_counter), 1);
    chk("early_p.lock",   32'(lock),      0);
    cyc(1'b1);
    chk("early_1cyc",     32'(err_early), 0);
    chk("early_next.n",   32'(N_counter), 2);
    run("relock", 3, 40, 34, -1, -1);

    // Dropped reference edge at c=48.
    run("pre_late", 41, 48, 34, 48, 51);
    cyc(1'b0);
    chk("late_p.late",  32'(err_late),  1);
    chk("late_p.n",     32'(N_counter), 0);
    chk("late_p.m",     32'(M_counter), 0);
    chk("late_p.divn",  32'(DIV_N),     0);
    chk("late_p.lock",  32'(lock),      0);
    cyc(1'b0);
    chk("late_1cyc",    32'(err_late),  0);
    chk("late_acq.n",   32'(N_counter), 0);
    for (int i = 0; i < 5; i++) cyc(1'b0);
    cyc(1'b1);
    chk("reacq_rise.n", 32'(N_counter), 0);
    run("reacq", 1, 36, 34, -1, -1);

    // Reset mid-frame while locked.
    rst_n = 1'b0;
    cyc(1'b0);
    chk_all_zero("midrst");
    rst_n = 1'b1;

    // Lower N from 8 to 3 while N_counter is 6.
    N = 4'd8;
    M = 2'd2;
    cyc(1'b0);
    cyc(1'b1);
    for (int c = 1; c <= 6; c++) begin
      cyc(c < 4);
      chk("n8.n", 32'(N_counter), 32'(c));
    end
    N = 4'd3;
    #1;
    chk("nlow.divn",  32'(DIV_N),     1);
    chk("nlow.divm",  32'(DIV_M),     0);
    cyc(1'b0);
    chk("nlow.n",     32'(N_counter), 1);
    chk("nlow.m",     32'(M_counter), 2);
    chk("nlow.divn2", 32'(DIV_N),     0);
    cyc(1'b0);
    chk("nlow.n2",    32'(N_counter), 2);

    // N=0, M=0 behaves as 1/1: every RUN cycle is a frame end.
    rst_n = 1'b0;
    N = 4'd0;
    M = 2'd0;
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    chk("z.n",    32'(N_counter), 1);
    chk("z.m",    32'(M_counter), 1);
    chk("z.divn", 32'(DIV_N),     1);
    chk("z.divm", 32'(DIV_M),     1);
    cyc(1'b0);
    chk("z.late", 32'(err_late),  1);
    chk("z.acq",  32'(N_counter), 0);

    // N=0, M=2 with a reference rise every 2 cycles stays aligned and locks.
    rst_n = 1'b0;
    M = 2'd2;
    cyc(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      cyc((c % 2) == 0);
      if (c >= 1) begin
        chk("n0.n",    32'(N_counter), 1);
        chk("n0.m",    32'(M_counter), 32'(((c % 2) == 1) ? 1 : 2));
        chk("n0.divn", 32'(DIV_N),     1);
        chk("n0.divm", 32'(DIV_M),     32'((c % 2) == 0));
        chk("n0.lock", 32'(lock),      32'(c >= 10));
        chk("n0.late", 32'(err_late),  0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
